lcd_cmd_seq: RTL and testbench

LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

---
 rtl/lcd_cmd_seq.sv | 129 ++++++++++++
 tb/tb_lcd_cmd_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: a small register-file of {addr,ctrl,data} entries
// replayed over a valid/ready port. Optional loop mode: LCD_CMD_SEQ_LOOP_EN.
module lcd_cmd_seq #(
  parameter  int DEPTH = 32,
  parameter  int AW    = 8,
  parameter  int CW    = 8,
  parameter  int DW    = 8,
  localparam int IW    = $clog2(DEPTH),
  localparam int EW    = AW + CW + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [EW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [EW-1:0] rd_data,
  input  logic          start,
  input  logic [IW:0]   count,
`ifdef LCD_CMD_SEQ_LOOP_EN
  input  logic          loop,
`endif
  input  logic          abort,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [AW-1:0] cmd_addr,
  output logic [CW-1:0] cmd_ctrl,
  output logic [DW-1:0] cmd_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nx;
  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_rd_data;
  logic [EW-1:0] r_cmd;
  logic [IW-1:0] r_ptr;
  logic [IW:0]   r_rem;
  logic [IW:0]   r_len;
  logic          r_loop;

  logic          w_acc, w_load, w_adv, w_reload, w_loop_in;
  logic [IW-1:0] w_ptr_nx;
  logic [IW:0]   w_len;

`ifdef LCD_CMD_SEQ_LOOP_EN
  assign w_loop_in = loop;
`else
  assign w_loop_in = 1'b0;
`endif

  assign w_acc    = (r_state == S_RUN) & cmd_ready;
  assign w_ptr_nx = r_ptr + 1'b1;
  assign w_len    = (count > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_adv      = 1'b0;
    w_reload   = 1'b0;
    case (r_state)
      S_IDLE:
        if (start) begin
          if (count == '0) w_state_nx = S_DONE;
          else begin
            w_state_nx = S_RUN;
            w_load     = 1'b1;
          end
        end
      S_RUN:
        // abort wins over a handshake in the same cycle
        if (abort) w_state_nx = S_IDLE;
        else if (w_acc) begin
          if (r_rem > (IW+1)'(1)) w_adv = 1'b1;
          else if (r_loop)        w_reload = 1'b1;
          else                    w_state_nx = S_DONE;
        end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // The presented command is a copy, so rewriting its source entry mid-stall is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_loop    <= 1'b0;
      r_cmd     <= '0;
      r_rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_rd_data <= r_mem[rd_idx];
      if (wr_en) r_mem[wr_idx] <= wr_data;
      if (w_load) begin
        r_ptr  <= '0;
        r_rem  <= w_len;
        r_len  <= w_len;
        r_loop <= w_loop_in;
        r_cmd  <= r_mem[0];
      end else if (w_adv) begin
        r_ptr <= w_ptr_nx;
        r_rem <= r_rem - 1'b1;
        r_cmd <= r_mem[w_ptr_nx];
      end else if (w_reload) begin
        r_ptr <= '0;
        r_rem <= r_len;
        r_cmd <= r_mem[0];
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign cmd_valid = (r_state == S_RUN);
  assign cmd_addr  = r_cmd[EW-1 -: AW];
  assign cmd_ctrl  = r_cmd[DW+CW-1 -: CW];
  assign cmd_data  = r_cmd[DW-1:0];
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: readback vector table, directed playback corners,
// and randomized playback against a queue-style model of the entry store.
module tb_lcd_cmd_seq;
  localparam int DEPTH = 32;
  localparam int IW    = 5;
  localparam int EW    = 24;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, abort, cmd_ready;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [EW-1:0] wr_data, rd_data;
  logic [IW:0]   count;
  logic          cmd_valid, busy, done;
  logic [7:0]    cmd_addr, cmd_ctrl, cmd_data;
`ifdef LCD_CMD_SEQ_LOOP_EN
  logic          loop;
`endif
  logic [EW-1:0] w_cmd;
  assign w_cmd = {cmd_addr, cmd_ctrl, cmd_data};

  lcd_cmd_seq #(.DEPTH(DEPTH), .AW(8), .CW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .start(start), .count(count),
`ifdef LCD_CMD_SEQ_LOOP_EN
    .loop(loop),
`endif
    .abort(abort), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  logic [EW-1:0] m [DEPTH];

  typedef struct {
    logic          we;
    logic [IW-1:0] wi;
    logic [EW-1:0] wd;
    logic [IW-1:0] ri;
    logic [EW-1:0] er;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int idx, input logic [EW-1:0] d);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_data = d; step(); wr_en = 1'b0;
    m[idx] = d;
  endtask

  // Plays min(cnt,DEPTH) entries with cmd_ready asserted pct% of cycles.
  task automatic play(input int cnt, input int pct);
    int n, k;
    logic rdy, pv, pr;
    logic [EW-1:0] pc;
    bit fin;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    k = 0; pv = 0; pr = 0; pc = '0; fin = 0;
    start = 1'b1; count = (IW+1)'(cnt); step(); start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (k == n) begin
        chk("done_after_last", done, 1'b1);
        chk("valid_after_last", cmd_valid, 1'b0);
        fin = 1;
      end else begin
        chk("valid_in_run", cmd_valid, 1'b1);
        if (pv && !pr) chk("stall_hold", w_cmd, pc);
        rdy = ($urandom_range(99) < pct);
        cmd_ready = rdy;
        if (rdy) begin chk("cmd_value", w_cmd, m[k]); k++; end
        pv = cmd_valid; pr = rdy; pc = w_cmd;
        step();
      end
    end
    chk("accepted_count", k, n);
    cmd_ready = 1'b0; step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd0,  24'h01A010, 5'd0,  24'h000000};
    tbl[1] = '{1'b1, 5'd1,  24'h02B020, 5'd0,  24'h01A010};
    tbl[2] = '{1'b1, 5'd2,  24'h03C030, 5'd1,  24'h02B020};
    tbl[3] = '{1'b0, 5'd0,  24'h000000, 5'd2,  24'h03C030};
    tbl[4] = '{1'b1, 5'd31, 24'hABCDEF, 5'd31, 24'h000000};
    tbl[5] = '{1'b0, 5'd0,  24'h000000, 5'd31, 24'hABCDEF};
    tbl[6] = '{1'b1, 5'd31, 24'h000000, 5'd31, 24'hABCDEF};
    tbl[7] = '{1'b0, 5'd0,  24'h000000, 5'd31, 24'h000000};
    for (int i = 0; i < DEPTH; i++) m[i] = '0;

    rst = 1'b1; wr_en = 0; wr_idx = 0; wr_data = 0; rd_idx = 0;
    start = 0; count = 0; abort = 0; cmd_ready = 0;
`ifdef LCD_CMD_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    // reset takes priority over a concurrent write and start
    step(); wr_en = 1'b1; wr_idx = 5'd3; wr_data = 24'h555555; start = 1'b1; count = 6'd3; step();
    wr_en = 1'b0; start = 1'b0; rst = 1'b0; step();
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cmd", w_cmd, 24'h0);
    rd_idx = 5'd3; step();
    chk("rst_entry3", rd_data, 24'h0);

    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].we; wr_idx = tbl[i].wi; wr_data = tbl[i].wd; rd_idx = tbl[i].ri;
      step();
      if (tbl[i].we) m[tbl[i].wi] = tbl[i].wd;
      chk($sformatf("tbl_rd%0d", i), rd_data, tbl[i].er);
    end
    wr_en = 1'b0;

    // three back-to-back commands, then one done cycle
    cmd_ready = 1'b1; start = 1'b1; count = 6'd3; step(); start = 1'b0;
    chk("b2b_v0", cmd_valid, 1'b1); chk("b2b_c0", w_cmd, 24'h01A010); step();
    chk("b2b_v1", cmd_valid, 1'b1); chk("b2b_c1", w_cmd, 24'h02B020); step();
    chk("b2b_v2", cmd_valid, 1'b1); chk("b2b_c2", w_cmd, 24'h03C030); step();
    chk("b2b_done", done, 1'b1); chk("b2b_nv", cmd_valid, 1'b0); chk("b2b_busy", busy, 1'b1); step();
    chk("b2b_done_off", done, 1'b0); chk("b2b_idle", busy, 1'b0);

    // stall on entry 1 for four cycles, rewriting it mid-stall
    start = 1'b1; count = 6'd3; step(); start = 1'b0;
    chk("st_c0", w_cmd, 24'h01A010); step();
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_hold_v", cmd_valid, 1'b1);
      chk("st_hold_c", w_cmd, 24'h02B020);
      if (i == 1) begin wr_en = 1'b1; wr_idx = 5'd1; wr_data = 24'hFFFFFF; end
      step();
      wr_en = 1'b0;
    end
    m[1] = 24'hFFFFFF;
    chk("st_hold5", w_cmd, 24'h02B020);
    cmd_ready = 1'b1; step();
    chk("st_c2", w_cmd, 24'h03C030); step();
    chk("st_done", done, 1'b1); step();
    wr(1, 24'h02B020);

    // zero-length playback
    start = 1'b1; count = 6'd0; step(); start = 1'b0;
    chk("z_done", done, 1'b1); chk("z_nv", cmd_valid, 1'b0); step();
    chk("z_done_off", done, 1'b0); chk("z_nv2", cmd_valid, 1'b0); chk("z_idle", busy, 1'b0);

    // abort beats a same-cycle handshake; start during RUN is ignored
    cmd_ready = 1'b1; start = 1'b1; count = 6'd3; step();
    count = 6'd0; step();
    chk("ab_ign_start_v", cmd_valid, 1'b1); chk("ab_ign_start_c", w_cmd, 24'h02B020);
    start = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    chk("ab_nv", cmd_valid, 1'b0); chk("ab_busy", busy, 1'b0); chk("ab_nodone", done, 1'b0); step();
    chk("ab_nodone2", done, 1'b0);
    start = 1'b1; count = 6'd1; step(); start = 1'b0;
    chk("ab_restart_c", w_cmd, 24'h01A010); step();
    chk("ab_restart_done", done, 1'b1); cmd_ready = 1'b0; step();

    // full length and over-length playback
    for (int i = 0; i < DEPTH; i++) wr(i, EW'($urandom));
    play(40, 100);
    play(32, 60);

    // random writes with readback, then random playbacks
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 8; j++) begin
        int wi, ri;
        logic [EW-1:0] d, e;
        wi = $urandom_range(DEPTH-1);
        ri = ($urandom_range(3) == 0) ? wi : $urandom_range(DEPTH-1);
        d = EW'($urandom);
        e = m[ri];
        wr_en = 1'b1; wr_idx = IW'(wi); wr_data = d; rd_idx = IW'(ri); step(); wr_en = 1'b0;
        m[wi] = d;
        chk("rnd_rd", rd_data, e);
      end
      play($urandom_range(40), $urandom_range(100, 30));
    end

`ifdef LCD_CMD_SEQ_LOOP_EN
    loop = 1'b1; cmd_ready = 1'b1; start = 1'b1; count = 6'd2; step(); start = 1'b0; loop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("lp_v", cmd_valid, 1'b1);
      chk("lp_c", w_cmd, m[i % 2]);
      chk("lp_nodone", done, 1'b0);
      step();
    end
    abort = 1'b1; step(); abort = 1'b0;
    chk("lp_ab_nv", cmd_valid, 1'b0); chk("lp_ab_busy", busy, 1'b0); chk("lp_ab_done", done, 1'b0);
    loop = 1'b1; start = 1'b1; count = 6'd2; step(); start = 1'b0; loop = 1'b0;
    step(); step();
`else
    cmd_ready = 1'b1; start = 1'b1; count = 6'd5; step(); start = 1'b0;
    cmd_ready = 1'b0; step();
`endif
    // reset mid-playback clears everything including the store
    chk("mr_pre_v", cmd_valid, 1'b1);
    rst = 1'b1; rd_idx = 5'd0; step();
    chk("mr_nv", cmd_valid, 1'b0); chk("mr_busy", busy, 1'b0); chk("mr_done", done, 1'b0);
    chk("mr_cmd", w_cmd, 24'h0); chk("mr_rd", rd_data, 24'h0);
    rst = 1'b0; cmd_ready = 1'b0; step();
    chk("mr_nodone", done, 1'b0); chk("mr_entry0", rd_data, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
